// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the memory-bus arbiter slice.
package mem_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_WAIT   = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_D  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Priority pick between fetch and load/store with a saturating starvation
// counter that forces fetch through after MAX_WAIT contended data wins.
module mem_arb_select
    import mem_bus_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   evaluate,
    output owner_e winner
);

    localparam int               CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    always_comb begin
        winner = NONE;
        if (d_req && !(if_req && (wait_cnt_q == CNT_MAX))) begin
            winner = OWN_D;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

    // Data can only beat a pending fetch below CNT_MAX, so the count saturates.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (evaluate) begin
            if (winner == OWN_IF) begin
                wait_cnt_d = '0;
            end else if ((winner == OWN_D) && if_req) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// outstanding transaction at a time, with back-to-back issue on the response cycle.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_W = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                winner;
    logic                  evaluate;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]       mem_be_q, mem_be_d;

    assign evaluate = (state_q == IDLE) || ((state_q == WAIT_RESP) && mem_rvalid);

    mem_arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_select (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .evaluate (evaluate),
        .winner   (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        case (state_q)
            IDLE, WAIT_RESP: begin
                if (evaluate) begin
                    owner_d   = winner;
                    mem_req_d = (winner != NONE);
                    state_d   = (winner == NONE) ? IDLE : ISSUE;
                    if (winner == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                    end else if (winner == OWN_IF) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = {BE_W{1'b1}};
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT_RESP;
                end
            end
            default: begin
                state_d   = IDLE;
                owner_d   = NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Handshake pulses are steered to the owner only; the other side stays quiet.
    assign if_gnt    = (state_q == ISSUE) && (owner_q == OWN_IF) && mem_gnt;
    assign d_gnt     = (state_q == ISSUE) && (owner_q == OWN_D) && mem_gnt;
    assign if_rvalid = (state_q == WAIT_RESP) && (owner_q == OWN_IF) && mem_rvalid;
    assign d_rvalid  = (state_q == WAIT_RESP) && (owner_q == OWN_D) && mem_rvalid;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
